// File: rtl/rom_pair_streamer_if.sv
// Pair stream from rom_pair_streamer into the NTT/butterfly datapath.
//   out_valid : a pair is available
//   out_ready : downstream accepts it; transfer when both are high
//   out_a     : even word of the pair
//   out_b     : odd word of the pair
// master = streamer side, slave = consumer side.
interface rom_pair_streamer_if #(
  parameter int WIDTH = 96
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;

  modport master (output out_valid, output out_a, output out_b, input out_ready);
  modport slave  (input out_valid, input out_a, input out_b, output out_ready);
endinterface

// File: rtl/rom_pair_streamer.sv
// Read-side sequencer for the registered-output dual-port ROM. A start pulse
// launches a run of consecutive word pairs (port A even, port B odd), which
// leave as a valid/ready pair stream through a 2-entry buffer. Reads are only
// issued while a buffer slot is guaranteed, so the stream never drops data.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, base, count  : run request, sampled in IDLE only
//   busy, done          : run in progress / one-cycle completion pulse
//   rom_en, rom_addra/b : ROM read request (combinational from state)
//   rom_doa, rom_dob    : ROM read data, one cycle after rom_en
//   out                 : pair stream (master side)
module rom_pair_streamer #(
  parameter int WIDTH  = 96,
  parameter int LENGTH = 1024,
  localparam int AW    = $clog2(LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [AW-1:0]            base,
  input  logic [AW-1:0]            count,
  output logic                     busy,
  output logic                     done,
  output logic                     rom_en,
  output logic [AW-1:0]            rom_addra,
  output logic [AW-1:0]            rom_addrb,
  input  logic [WIDTH-1:0]         rom_doa,
  input  logic [WIDTH-1:0]         rom_dob,
  rom_pair_streamer_if.master      out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [AW-1:0]    base_q;
  logic [AW-1:0]    count_q;
  logic [AW-1:0]    addra_q;
  logic [AW-1:0]    addrb_q;
  logic [AW:0]      issued;
  logic [AW:0]      popped;
  logic             pend;
  logic [WIDTH-1:0] mem_a [2];
  logic [WIDTH-1:0] mem_b [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       occ;

  logic             pop;
  logic             issue;
  logic [2:0]       credit_use;
  logic [AW-1:0]    pair_off;
  logic [AW-1:0]    issue_addra;
  logic [AW-1:0]    issue_addrb;
  logic [AW:0]      popped_nxt;

  always_comb begin
    pop         = (occ != 2'd0) && out.out_ready;
    // Slots already claimed after this cycle's pop: buffered plus in flight.
    credit_use  = {1'b0, occ} - {2'b00, pop} + {2'b00, pend};
    issue       = (state == S_RUN) && (issued < {1'b0, count_q}) && (credit_use < 3'd2);
    pair_off    = issued[AW-1:0] << 1;
    issue_addra = base_q + pair_off;
    issue_addrb = issue_addra + AW'(1);
    popped_nxt  = popped + {{AW{1'b0}}, pop};
  end

  assign rom_en    = issue;
  assign rom_addra = issue ? issue_addra : addra_q;
  assign rom_addrb = issue ? issue_addrb : addrb_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // With a 2-entry ring and wr_ptr == rd_ptr when empty, the slot behind the
  // read pointer still holds the last popped pair, so an empty buffer keeps
  // showing it without a separate holding register.
  assign out.out_valid = (occ != 2'd0);
  assign out.out_a     = (occ != 2'd0) ? mem_a[rd_ptr] : mem_a[~rd_ptr];
  assign out.out_b     = (occ != 2'd0) ? mem_b[rd_ptr] : mem_b[~rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      addra_q <= '0;
      addrb_q <= '0;
      issued  <= '0;
      popped  <= '0;
      pend    <= 1'b0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      occ     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base;
            count_q <= count;
            issued  <= '0;
            popped  <= '0;
            state   <= (count == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            issued  <= issued + 1'b1;
            addra_q <= issue_addra;
            addrb_q <= issue_addrb;
          end
          popped <= popped_nxt;
          if (popped_nxt == {1'b0, count_q}) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      pend <= issue;
      if (pend) begin
        mem_a[wr_ptr] <= rom_doa;
        mem_b[wr_ptr] <= rom_dob;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, pend} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_rom_pair_streamer.sv
module tb_rom_pair_streamer;

  localparam int WIDTH  = 8;
  localparam int LENGTH = 16;
  localparam int AW     = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_i;
  logic [AW-1:0] count_i;
  logic          busy;
  logic          done;
  logic          rom_en;
  logic [AW-1:0] rom_addra;
  logic [AW-1:0] rom_addrb;
  logic [WIDTH-1:0] rom_doa = '0;
  logic [WIDTH-1:0] rom_dob = '0;

  int checks   = 0;
  int failures = 0;

  rom_pair_streamer_if #(.WIDTH(WIDTH)) sif ();

  rom_pair_streamer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base_i),
    .count     (count_i),
    .busy      (busy),
    .done      (done),
    .rom_en    (rom_en),
    .rom_addra (rom_addra),
    .rom_addrb (rom_addrb),
    .rom_doa   (rom_doa),
    .rom_dob   (rom_dob),
    .out       (sif)
  );

  always #5 clk = ~clk;

  // ROM model: word k holds k, registered output, holds while en is low.
  always @(posedge clk) begin
    if (rom_en) begin
      rom_doa <= {4'b0000, rom_addra};
      rom_dob <= {4'b0000, rom_addrb};
    end
  end

  typedef struct {
    logic [3:0]  base;
    logic [3:0]  count;
    logic [5:0]  mask;      // out_ready pattern, bit (k-1)%period at cycle k
    int          period;
    int          inj_k;     // cycle of a spurious start (base=8), 0 = none
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    int          exp_done;  // cycle (after start edge) holding the done pulse
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int mstate, occ, pend, issued, popped, pop, en_exp, done_k;
    logic [3:0] ea, eb;
    logic [7:0] first_a, last_a, prev_a, prev_b;
    bit prev_stall, fin;
    @(negedge clk);
    base_i = v.base; count_i = v.count; start = 1'b1; sif.out_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    mstate = (v.count == 0) ? 2 : 1;
    occ = 0; pend = 0; issued = 0; popped = 0; done_k = 0;
    prev_stall = 0; fin = 0; first_a = '0; last_a = '0; prev_a = '0; prev_b = '0;
    for (int k = 1; k <= 60 && !fin; k++) begin
      @(negedge clk);
      start = (k == v.inj_k);
      if (start) base_i = 4'd8;
      sif.out_ready = v.mask[(k-1) % v.period];
      #1;
      pop    = (occ != 0 && sif.out_ready) ? 1 : 0;
      en_exp = (mstate == 1 && issued < int'(v.count) && (occ - pop + pend) < 2) ? 1 : 0;
      chk("busy", busy, (mstate != 0));
      chk("done", done, (mstate == 2));
      chk("rom_en", rom_en, en_exp);
      if (en_exp != 0) begin
        ea = v.base + 4'(2 * issued);
        eb = ea + 4'd1;
        chk("rom_addra", rom_addra, ea);
        chk("rom_addrb", rom_addrb, eb);
      end
      chk("out_valid", sif.out_valid, (occ != 0));
      if (prev_stall && occ != 0) begin
        chk("stall_a", sif.out_a, prev_a);
        chk("stall_b", sif.out_b, prev_b);
      end
      if (pop != 0) begin
        ea = v.base + 4'(2 * popped);
        eb = ea + 4'd1;
        chk("out_a", sif.out_a, {4'b0000, ea});
        chk("out_b", sif.out_b, {4'b0000, eb});
        if (popped == 0) first_a = sif.out_a;
        last_a = sif.out_a;
      end
      prev_stall = (occ != 0) && !sif.out_ready;
      prev_a = sif.out_a;
      prev_b = sif.out_b;
      if (mstate == 0) fin = 1;
      else if (mstate == 2) begin
        mstate = 0;
        done_k = k;
      end else begin
        occ = occ - pop + pend;
        if (occ > 2) chk("overflow", occ, 2);
        pend   = en_exp;
        issued += en_exp;
        popped += pop;
        if (popped == int'(v.count)) mstate = 2;
      end
    end
    start = 1'b0;
    sif.out_ready = 1'b0;
    chk("finished", fin, 1);
    chk("done_cycle", done_k, v.exp_done);
    chk("pairs", popped, v.count);
    if (v.count != 0) begin
      chk("first_a", first_a, v.exp_first);
      chk("last_a", last_a, v.exp_last);
    end
  endtask

  initial begin
    vecs[0] = '{base: 4'd0,  count: 4'd5 - 4'd1, mask: 6'b000001, period: 1, inj_k: 0,
                exp_first: 8'd0,  exp_last: 8'd6,  exp_done: 7};
    vecs[1] = '{base: 4'd12, count: 4'd3, mask: 6'b000001, period: 1, inj_k: 0,
                exp_first: 8'd12, exp_last: 8'd0,  exp_done: 6};
    vecs[2] = '{base: 4'd5,  count: 4'd0, mask: 6'b000001, period: 1, inj_k: 0,
                exp_first: 8'd0,  exp_last: 8'd0,  exp_done: 1};
    vecs[3] = '{base: 4'd2,  count: 4'd5, mask: 6'b101001, period: 6, inj_k: 0,
                exp_first: 8'd2,  exp_last: 8'd10, exp_done: 13};
    vecs[4] = '{base: 4'd0,  count: 4'd4, mask: 6'b000001, period: 1, inj_k: 2,
                exp_first: 8'd0,  exp_last: 8'd6,  exp_done: 7};

    rst_n = 1'b0; start = 1'b0; base_i = '0; count_i = '0; sif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_addra", rom_addra, 0);
    chk("rst_addrb", rom_addrb, 0);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_out_a", sif.out_a, 0);
    chk("rst_out_b", sif.out_b, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset mid-run: base=4, count=6, abort after the second pair.
    @(negedge clk);
    base_i = 4'd4; count_i = 4'd6; start = 1'b1; sif.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (k == 3) chk("mid_pair0", sif.out_a, 8'd4);
      if (k == 4) chk("mid_pair1", sif.out_a, 8'd6);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rom_en", rom_en, 0);
    chk("abort_addra", rom_addra, 0);
    chk("abort_addrb", rom_addrb, 0);
    chk("abort_valid", sif.out_valid, 0);
    chk("abort_out_a", sif.out_a, 0);
    chk("abort_out_b", sif.out_b, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("post_abort_done", done, 0);
      chk("post_abort_valid", sif.out_valid, 0);
      chk("post_abort_rom_en", rom_en, 0);
    end
    run_vec('{base: 4'd6, count: 4'd2, mask: 6'b000001, period: 1, inj_k: 0,
              exp_first: 8'd6, exp_last: 8'd8, exp_done: 5});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
